// File: rtl/mult_ctrl_pkg.sv
// Shared types and decode helpers for the EX-stage multiply sequencer.
// Contents: state/sign-class enums, reuse tag payload, ALU multiply func
// codes, func -> sign-class and func -> result-half decoders.
package mult_ctrl_pkg;

  localparam int unsigned MULT_LAT_MIN = 1;
  localparam int unsigned XLEN         = 32;
  localparam int unsigned FUNC_W       = 5;
  localparam int unsigned PROD_W       = 66;

  // ALU function codes for the multiply group
  localparam logic [FUNC_W-1:0] ALU_MUL    = 5'h0a;
  localparam logic [FUNC_W-1:0] ALU_MULH   = 5'h0b;
  localparam logic [FUNC_W-1:0] ALU_MULHSU = 5'h0c;
  localparam logic [FUNC_W-1:0] ALU_MULHU  = 5'h0d;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  // Operand signedness: first letter opa, second letter opb
  typedef enum logic [1:0] {
    UU = 2'd0,
    SU = 2'd1,
    SS = 2'd2
  } mult_sign_e;

  // Identifies a stored product for reuse
  typedef struct packed {
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    mult_sign_e      sign;
  } mult_tag_t;

  // MUL shares the UU class: the low half is identical for every class
  function automatic mult_sign_e func_sign(input logic [FUNC_W-1:0] func);
    mult_sign_e s;
    case (func)
      ALU_MULH:   s = SS;
      ALU_MULHSU: s = SU;
      default:    s = UU;
    endcase
    return s;
  endfunction

  function automatic logic func_high(input logic [FUNC_W-1:0] func);
    return (func == ALU_MULH) || (func == ALU_MULHSU) || (func == ALU_MULHU);
  endfunction

  function automatic logic [XLEN-1:0] sel_half(input logic [2*XLEN-1:0] prod,
                                               input logic [FUNC_W-1:0] func);
    return func_high(func) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
  endfunction

endpackage

// File: rtl/mult_lat_counter.sv
// Loadable down-counter with a registered zero flag.
// Ports: clock, reset_n (async active-low), load_i/load_val_i load a new
// count, dec_i decrements (saturating at zero), zero_o is high when the
// held count is zero.
module mult_lat_counter #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;

  // Next count; the zero flag tracks the next count so it stays registered
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    zero_d = (cnt_d == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Multi-cycle sequencer for the EX-stage integer multiplier.
// Registers operands/func toward a combinational multiplier, holds them for
// MULT_LAT cycles, captures the product, selects the 32-bit result half and
// stalls the pipeline until the one-cycle mult_done pulse.
// Optional feature macro: MULT_REUSE_EN keeps the last product and its
// operand/sign tag so a matching request skips the multiplier.
// Ports:
//   clock, reset_n           clock, async active-low reset
//   mult_req, opa, opb,
//   ID_EX_alu_func           multiply request from ID/EX
//   flush                    squash any in-flight multiply
//   mult_opa/opb/func        registered multiplier inputs
//   mult_result              66-bit product from the multiplier
//   mult_stall               combinational pipeline freeze
//   mult_done, mult_out      result pulse and held result
module mult_seq_ctrl
  import mult_ctrl_pkg::*;
#(
  parameter int unsigned MULT_LAT = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              mult_req,
  input  logic [XLEN-1:0]   opa,
  input  logic [XLEN-1:0]   opb,
  input  logic [FUNC_W-1:0] ID_EX_alu_func,
  input  logic              flush,
  output logic [XLEN-1:0]   mult_opa,
  output logic [XLEN-1:0]   mult_opb,
  output logic [FUNC_W-1:0] mult_func,
  input  logic [PROD_W-1:0] mult_result,
  output logic              mult_stall,
  output logic              mult_done,
  output logic [XLEN-1:0]   mult_out
);

  localparam int unsigned LAT_EFF = (MULT_LAT < MULT_LAT_MIN) ? MULT_LAT_MIN : MULT_LAT;
  localparam int unsigned CNT_W   = (LAT_EFF > 1) ? $clog2(LAT_EFF) : 1;

  mult_state_e       state_q, state_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [FUNC_W-1:0] func_q, func_d;
  logic [XLEN-1:0]   out_q, out_d;
  logic              done_q, done_d;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic              tag_hit;
  logic [2*XLEN-1:0] reuse_prod;

  // Sign-extension bits above the 64-bit product never reach the result
  logic unused_prod_hi;
  assign unused_prod_hi = ^mult_result[PROD_W-1:2*XLEN];

  mult_lat_counter #(
    .CNT_W (CNT_W)
  ) u_lat_cnt (
    .clock      (clock),
    .reset_n    (reset_n),
    .load_i     (cnt_load),
    .load_val_i (CNT_W'(LAT_EFF - 1)),
    .dec_i      (cnt_dec),
    .zero_o     (cnt_zero)
  );

`ifdef MULT_REUSE_EN
  mult_tag_t         tag_q;
  logic              tag_vld_q;
  logic [2*XLEN-1:0] prod_q;
  mult_tag_t         req_tag;
  logic              tag_wr;

  assign req_tag    = '{opa: opa, opb: opb, sign: func_sign(ID_EX_alu_func)};
  assign tag_hit    = tag_vld_q && (tag_q == req_tag);
  assign reuse_prod = prod_q;
  // Only a product captured through the multiplier refreshes the tag
  assign tag_wr     = (state_q == BUSY) && cnt_zero && !flush;

  // Product/tag store; flush leaves it intact since the stored pair stays valid
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tag_q     <= '0;
      tag_vld_q <= 1'b0;
      prod_q    <= '0;
    end else if (tag_wr) begin
      tag_q     <= '{opa: opa_q, opb: opb_q, sign: func_sign(func_q)};
      tag_vld_q <= 1'b1;
      prod_q    <= mult_result[2*XLEN-1:0];
    end
  end
`else
  assign tag_hit    = 1'b0;
  assign reuse_prod = '0;
`endif

  // Next-state and datapath register updates
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    func_d   = func_q;
    out_d    = out_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;

    case (state_q)
      IDLE: begin
        if (mult_req && !flush) begin
          opa_d  = opa;
          opb_d  = opb;
          func_d = ID_EX_alu_func;
          if (tag_hit) begin
            out_d   = sel_half(reuse_prod, ID_EX_alu_func);
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            cnt_load = 1'b1;
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_zero) begin
          out_d   = sel_half(mult_result[2*XLEN-1:0], func_q);
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Squash: back to IDLE, result and done suppressed
    if (flush) begin
      state_d  = IDLE;
      out_d    = out_q;
      done_d   = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      func_q  <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      func_q  <= func_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  assign mult_stall = !flush && (((state_q == IDLE) && mult_req) || (state_q == BUSY));
  assign mult_opa   = opa_q;
  assign mult_opb   = opb_q;
  assign mult_func  = func_q;
  assign mult_done  = done_q;
  assign mult_out   = out_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
module tb_mult_seq_ctrl;
  import mult_ctrl_pkg::*;

  localparam int unsigned LAT = 2;

  logic              clock;
  logic              reset_n;
  logic              mult_req;
  logic [31:0]       opa, opb;
  logic [4:0]        ID_EX_alu_func;
  logic              flush;
  logic [31:0]       mult_opa, mult_opb;
  logic [4:0]        mult_func;
  logic [65:0]       mult_result;
  logic              mult_stall;
  logic              mult_done;
  logic [31:0]       mult_out;

  mult_seq_ctrl #(.MULT_LAT(LAT)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .mult_req       (mult_req),
    .opa            (opa),
    .opb            (opb),
    .ID_EX_alu_func (ID_EX_alu_func),
    .flush          (flush),
    .mult_opa       (mult_opa),
    .mult_opb       (mult_opb),
    .mult_func      (mult_func),
    .mult_result    (mult_result),
    .mult_stall     (mult_stall),
    .mult_done      (mult_done),
    .mult_out       (mult_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in combinational multiplier (33x33 signed, class from func)
  logic signed [65:0] ma, mb;
  always_comb begin
    mult_sign_e s;
    s  = func_sign(mult_func);
    ma = {{34{(s != UU) & mult_opa[31]}}, mult_opa};
    mb = {{34{(s == SS) & mult_opb[31]}}, mult_opb};
    mult_result = 66'(ma * mb);
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference reuse tag (only consulted when the reuse feature is built in)
  logic        rt_v;
  logic [31:0] rt_a, rt_b;
  mult_sign_e  rt_s;

  task automatic run_op(input string name, input logic [4:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat_exp, lat, stalls;
    bit seen;
    lat_exp = int'(LAT) + 1;
`ifdef MULT_REUSE_EN
    if (rt_v && rt_a == a && rt_b == b && rt_s == func_sign(f)) lat_exp = 1;
`endif
    @(negedge clock);
    mult_req = 1'b1; opa = a; opb = b; ID_EX_alu_func = f;
    #1;
    check({name, "_stall_t0"}, 32'(mult_stall), 32'd1);
    stalls = 1; lat = 0; seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock); #1;
      if (mult_done) begin lat = c; seen = 1'b1; break; end
      if (mult_stall) stalls++;
      opa = ~a; opb = ~b;  // operand registers must not follow the inputs
    end
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_timeout: no mult_done within 20 cycles", name);
    end else begin
      check({name, "_out"},     mult_out,           exp);
      check({name, "_lat"},     32'(lat),           32'(lat_exp));
      check({name, "_stalls"},  32'(stalls),        32'(lat_exp));
      check({name, "_stall_dn"},32'(mult_stall),    32'd0);
      check({name, "_opa"},     mult_opa,           a);
    end
    if (lat_exp != 1) begin
      rt_v = 1'b1; rt_a = a; rt_b = b; rt_s = func_sign(f);
    end
    mult_req = 1'b0; opa = '0; opb = '0;
  endtask

  typedef struct {
    string       name;
    logic [4:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[12];
  int   done_cnt;
  logic [31:0] held;

  initial begin
    vecs[0]  = '{"mul_7x6",      ALU_MUL,    32'd7,          32'd6,          32'd42};
    vecs[1]  = '{"mulh_min",     ALU_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000};
    vecs[2]  = '{"mulhu_min",    ALU_MULHU,  32'h8000_0000,  32'h8000_0000,  32'h4000_0000};
    vecs[3]  = '{"mulhsu_m1x2",  ALU_MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF};
    vecs[4]  = '{"mul_ones",     ALU_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
    vecs[5]  = '{"mulhu_ones",   ALU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
    vecs[6]  = '{"mulh_ones",    ALU_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000};
    vecs[7]  = '{"mulhsu_mix",   ALU_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    vecs[8]  = '{"other_3x5",    5'h00,      32'd3,          32'd5,          32'd15};
    vecs[9]  = '{"mulh_m3x5",    ALU_MULH,   32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFFF};
    vecs[10] = '{"mul_m3x5",     ALU_MUL,    32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1};
    vecs[11] = '{"mulhu_m3x5",   ALU_MULHU,  32'hFFFF_FFFD,  32'd5,          32'h0000_0004};

    reset_n = 1'b0; mult_req = 1'b0; opa = '0; opb = '0; ID_EX_alu_func = '0; flush = 1'b0;
    rt_v = 1'b0; rt_a = '0; rt_b = '0; rt_s = UU;
    #2;
    check("rst_opa",   mult_opa,          32'd0);
    check("rst_opb",   mult_opb,          32'd0);
    check("rst_func",  32'(mult_func),    32'd0);
    check("rst_out",   mult_out,          32'd0);
    check("rst_done",  32'(mult_done),    32'd0);
    check("rst_stall", 32'(mult_stall),   32'd0);
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 12; i++)
      run_op(vecs[i].name, vecs[i].func, vecs[i].a, vecs[i].b, vecs[i].exp);

    // Flush during the first BUSY cycle
    held = mult_out;
    @(negedge clock);
    mult_req = 1'b1; opa = 32'd9; opb = 32'd9; ID_EX_alu_func = ALU_MUL;
    @(negedge clock); #1;
    flush = 1'b1; mult_req = 1'b0;
    #1;
    check("flush_stall_now", 32'(mult_stall), 32'd0);
    @(negedge clock); #1;
    flush = 1'b0;
    check("flush_stall_after", 32'(mult_stall), 32'd0);
    check("flush_done",        32'(mult_done),  32'd0);
    check("flush_out_held",    mult_out,        held);
    done_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock); #1;
      if (mult_done) done_cnt++;
    end
    check("flush_no_done", 32'(done_cnt), 32'd0);
    check("flush_out_held2", mult_out, held);
    run_op("mul_after_flush", ALU_MUL, 32'd9, 32'd9, 32'd81);

    // Asynchronous reset in the middle of BUSY
    @(negedge clock);
    mult_req = 1'b1; opa = 32'h1234; opb = 32'h10; ID_EX_alu_func = ALU_MUL;
    @(negedge clock); #1;
    reset_n = 1'b0; mult_req = 1'b0;
    #1;
    check("arst_opa",   mult_opa,        32'd0);
    check("arst_opb",   mult_opb,        32'd0);
    check("arst_func",  32'(mult_func),  32'd0);
    check("arst_out",   mult_out,        32'd0);
    check("arst_done",  32'(mult_done),  32'd0);
    check("arst_stall", 32'(mult_stall), 32'd0);
    rt_v = 1'b0;
    @(negedge clock); @(negedge clock);
    reset_n = 1'b1;
    run_op("mul_after_rst", ALU_MUL, 32'd3, 32'd5, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
